// File: rtl/alu_div.sv
// rtl/alu_div.sv - 32-bit radix-2 restoring divider, signed/unsigned, with div-by-zero and overflow flags
module alu_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Sign,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero,
    output logic        out_of_range
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [31:0] bmag_q, bmag_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rmd_q, rmd_d;
    logic        dz_q, dz_d;
    logic        oor_q, oor_d;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_shift, trial;
    logic        q_neg_fix, r_neg_fix;

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign quotient     = quo_q;
    assign remainder    = rmd_q;
    assign div_zero     = dz_q;
    assign out_of_range = oor_q;

    // Operand magnitudes, one trial-subtract step, and sign-correction selects
    always_comb begin
        accept    = start && ((state_q == IDLE) || (state_q == DONE));
        a_neg     = Sign & A[31];
        b_neg     = Sign & B[31];
        a_mag     = a_neg ? (~A + 32'd1) : A;
        b_mag     = b_neg ? (~B + 32'd1) : B;
        rem_shift = {rem_q[31:0], dvd_q[31]};
        trial     = rem_shift - {1'b0, bmag_q};
        q_neg_fix = sign_q & (a_q[31] ^ b_q[31]);
        r_neg_fix = sign_q & a_q[31];
    end

    // Next-state and datapath: capture on accept, 32 CALC steps, FIX registers results
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    sign_d  = Sign;
                    bmag_d  = b_mag;
                    rem_d   = 33'd0;
                    dvd_d   = a_mag;
                    cnt_d   = 6'd0;
                    dz_d    = 1'b0;
                    oor_d   = 1'b0;
                    // A zero divisor bypasses the iterations entirely
                    state_d = (B == 32'd0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (!trial[32]) begin
                    rem_d = trial;
                end else begin
                    rem_d = rem_shift;
                end
                dvd_d = {dvd_q[30:0], ~trial[32]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (b_q == 32'd0) begin
                    quo_d = 32'hFFFF_FFFF;
                    rmd_d = a_q;
                    dz_d  = 1'b1;
                end else begin
                    quo_d = q_neg_fix ? (~dvd_q + 32'd1) : dvd_q;
                    rmd_d = r_neg_fix ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
                    // The magnitude path already yields 0x80000000 r 0 here; only the flag is extra
                    oor_d = sign_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sign_q  <= 1'b0;
            bmag_q  <= 32'd0;
            rem_q   <= 33'd0;
            dvd_q   <= 32'd0;
            quo_q   <= 32'd0;
            rmd_q   <= 32'd0;
            dz_q    <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            oor_q   <= oor_d;
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - randomized self-checking bench for alu_div against an arithmetic reference model
module tb_alu_div;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Sign = 1'b0;
    logic        busy, done, div_zero, out_of_range;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    logic armed = 1'b0;

    alu_div dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Sign(Sign),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: what a divide must return, from plain integer rules
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z, output logic o);
        int sa, sb;
        z = 1'b0;
        o = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            o = 1'b1;
        end else if (s) begin
            sa = a;
            sb = b;
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Transaction-level model: cycles remaining until result, held outputs
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_q = 32'd0, m_r = 32'd0, p_q = 32'd0, p_r = 32'd0;
    logic        m_z = 1'b0, m_o = 1'b0, p_z = 1'b0, p_o = 1'b0;

    always @(posedge clk) begin
        logic [31:0] tq, tr;
        logic        tz, to;
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
            m_q <= 32'd0; m_r <= 32'd0; m_z <= 1'b0; m_o <= 1'b0;
        end else if (start && (!m_busy || m_done)) begin
            ref_div(A, B, Sign, tq, tr, tz, to);
            p_q <= tq; p_r <= tr; p_z <= tz; p_o <= to;
            m_busy <= 1'b1; m_done <= 1'b0;
            m_cnt <= (B == 32'd0) ? 1 : 33;
            m_z <= 1'b0; m_o <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0; m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_q <= p_q; m_r <= p_r; m_z <= p_z; m_o <= p_o;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({busy, done, quotient, remainder, div_zero, out_of_range} !==
                {m_busy, m_done, m_q, m_r, m_z, m_o}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got busy=%b done=%b q=%h r=%h z=%b o=%b exp busy=%b done=%b q=%h r=%h z=%b o=%b",
                         $time, busy, done, quotient, remainder, div_zero, out_of_range,
                         m_busy, m_done, m_q, m_r, m_z, m_o);
            end
        end
    end

    // Issue one divide, optionally disturb inputs while busy, check latency and literal result
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ez, input logic eo, input logic noise, input string name);
        int n;
        int lat;
        logic got;
        lat = (b == 32'd0) ? 2 : 34;
        A = a; B = b; Sign = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                A = $urandom;
                B = $urandom;
                Sign = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        checks++;
        if (!got || n != lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d done_seen=%b exp=%0d", name, n, got, lat);
        end
        checks++;
        if ({quotient, remainder, div_zero, out_of_range} !== {eq, er, ez, eo}) begin
            errors++;
            $display("FAIL %s_result got q=%h r=%h z=%b o=%b exp q=%h r=%h z=%b o=%b",
                     name, quotient, remainder, div_zero, out_of_range, eq, er, ez, eo);
        end
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        rs, ez, eo, saw;
        int          cls;
        repeat (2) @(posedge clk);
        #1 armed = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_zero, out_of_range} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h z=%b o=%b exp all zero",
                     busy, done, quotient, remainder, div_zero, out_of_range);
        end

        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "s_m7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 1'b0, "u_fff9_2");
        run_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "div0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, "ovf");
        run_op(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, "u10_3");
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1, "busy_noise");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, "u_max_1");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0, "back2back");

        // Reset landing at E20 of an operation aborts it
        A = 32'd100; B = 32'd7; Sign = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_zero, out_of_range} !== 66'd0) begin
            errors++;
            $display("FAIL midop_reset got busy=%b done=%b q=%h r=%h exp all zero",
                     busy, done, quotient, remainder);
        end
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL aborted_done got done_seen=1 exp 0");
        end

        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, "after_reset");

        for (int k = 0; k < 30; k++) begin
            cls = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (cls == 0) rb = 32'd0;
            else if (cls == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
            else if (cls < 5) rb = $urandom_range(1, 20);
            else if (cls == 5) rb = -32'($urandom_range(1, 20));
            ref_div(ra, rb, rs, eq, er, ez, eo);
            run_op(ra, rb, rs, eq, er, ez, eo, 1'($urandom_range(0, 1)), "random");
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
